ddr_rd_ctrl: RTL and testbench

DDR-side read sequencer between the two-part video read buffer and the memory controller's AXI-style read port. It accepts one line request per handshake and serves left-half (part 0) then right-half (part 1). Each part is split into AXI bursts of at most MAX_BURST beats. Returned beats are steered to the matching part's write-enable, and the part-select line drives the address/length mux.

---
 rtl/ddr_rd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ddr_rd_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_ctrl.sv
// rtl/ddr_rd_ctrl.sv - DDR-side two-part line read sequencer onto an AXI-style read port
//
// Accepts one line request per handshake and reads part 0 then part 1, each split
// into bursts of at most MAX_BURST beats. Returned beats are registered and
// steered to the write-enable of the part currently being served.
//
// Ports:
//   ddr_clk, ddr_rstn        clock, asynchronous active-low reset
//   init_done                DDR calibrated; gates request acceptance
//   ddr_rreq / ddr_rrdy      line request level / one-cycle accept pulse
//   ddr_raddr, ddr_rd_len    start address and beat count of the selected part
//   ddr_rdone                one-cycle pulse at the end of each part
//   ddr_rdata, ddr_rdata_en1/en2   registered read beat and per-part valid
//   rd_opera_en_2            part select driving the upstream address/length mux
//   axi_ar*, axi_r*          AXI-style read address and read data channels
module ddr_rd_ctrl #(
    parameter int ADDR_WIDTH = 27,
    parameter int DQ_WIDTH   = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16,
    parameter int ADDR_STEP  = 8
) (
    input  logic                    ddr_clk,
    input  logic                    ddr_rstn,
    input  logic                    init_done,
    input  logic                    ddr_rreq,
    input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
    input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
    output logic                    ddr_rrdy,
    output logic                    ddr_rdone,
    output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
    output logic                    ddr_rdata_en1,
    output logic                    ddr_rdata_en2,
    output logic                    rd_opera_en_2,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
    input  logic                    axi_rvalid,
    output logic                    axi_rready
);

    typedef enum logic [2:0] {IDLE, LOAD, ADDR, DATA, NEXT} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [LEN_WIDTH-1:0]   remain;
    logic [LEN_WIDTH-1:0]   beats;
    logic [LEN_WIDTH-1:0]   cnt;

    logic [LEN_WIDTH-1:0]   rem_next;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic                   last_beat;

    function automatic logic [LEN_WIDTH-1:0] clip(input logic [LEN_WIDTH-1:0] n);
        return (n > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST) : n;
    endfunction

    // Values the part will have once the current burst's last beat lands.
    always_comb begin
        rem_next  = remain - beats;
        addr_next = cur_addr + ADDR_WIDTH'(beats) * ADDR_WIDTH'(ADDR_STEP);
        last_beat = axi_rvalid && (cnt == beats - LEN_WIDTH'(1));
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state         <= IDLE;
            rd_opera_en_2 <= 1'b0;
            cur_addr      <= '0;
            remain        <= '0;
            beats         <= '0;
            cnt           <= '0;
            ddr_rrdy      <= 1'b0;
            ddr_rdone     <= 1'b0;
            ddr_rdata     <= '0;
            ddr_rdata_en1 <= 1'b0;
            ddr_rdata_en2 <= 1'b0;
            axi_araddr    <= '0;
            axi_arlen     <= '0;
            axi_arvalid   <= 1'b0;
            axi_rready    <= 1'b0;
        end else begin
            ddr_rrdy      <= 1'b0;
            ddr_rdone     <= 1'b0;
            ddr_rdata_en1 <= axi_rvalid & axi_rready & ~rd_opera_en_2;
            ddr_rdata_en2 <= axi_rvalid & axi_rready & rd_opera_en_2;
            if (axi_rvalid && axi_rready) begin
                ddr_rdata <= axi_rdata;
            end

            case (state)
                IDLE: begin
                    if (ddr_rreq && init_done) begin
                        ddr_rrdy      <= 1'b1;
                        rd_opera_en_2 <= 1'b0;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    cur_addr <= ddr_raddr;
                    remain   <= ddr_rd_len;
                    if (ddr_rd_len == '0) begin
                        // rdone is raised on entry so it coincides with NEXT,
                        // while the part select still shows the finishing part.
                        ddr_rdone <= 1'b1;
                        state     <= NEXT;
                    end else begin
                        axi_arvalid <= 1'b1;
                        axi_araddr  <= ddr_raddr;
                        axi_arlen   <= 8'(clip(ddr_rd_len) - LEN_WIDTH'(1));
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        beats       <= clip(remain);
                        cnt         <= '0;
                        axi_rready  <= 1'b1;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    // Beat count, not rlast, closes the burst.
                    if (last_beat) begin
                        axi_rready <= 1'b0;
                        remain     <= rem_next;
                        cur_addr   <= addr_next;
                        if (rem_next != '0) begin
                            axi_arvalid <= 1'b1;
                            axi_araddr  <= addr_next;
                            axi_arlen   <= 8'(clip(rem_next) - LEN_WIDTH'(1));
                            state       <= ADDR;
                        end else begin
                            ddr_rdone <= 1'b1;
                            state     <= NEXT;
                        end
                    end else if (axi_rvalid) begin
                        cnt <= cnt + LEN_WIDTH'(1);
                    end
                end
                NEXT: begin
                    // Going back through LOAD gives the upstream mux a cycle to
                    // present part 1's address and length.
                    if (!rd_opera_en_2) begin
                        rd_opera_en_2 <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        rd_opera_en_2 <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// tb/tb_ddr_rd_ctrl.sv - scoreboard bench for ddr_rd_ctrl
module tb_ddr_rd_ctrl;
    localparam int AW   = 27;
    localparam int DW   = 256;
    localparam int LW   = 16;
    localparam int MB   = 16;
    localparam int STEP = 8;

    logic           clk = 1'b0;
    logic           rstn, init_done, rreq;
    logic [AW-1:0]  raddr;
    logic [LW-1:0]  rd_len;
    logic           rrdy, rdone, en1, en2, part_sel;
    logic [DW-1:0]  rdata;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic           arvalid, arready, rvalid, rready;
    logic [DW-1:0]  axi_rdata;

    logic [AW-1:0]  line_addr0, line_addr1;
    logic [LW-1:0]  line_len0, line_len1;

    // Upstream mux follows the part select, as the read buffer does.
    assign raddr  = part_sel ? line_addr1 : line_addr0;
    assign rd_len = part_sel ? line_len1  : line_len0;

    ddr_rd_ctrl dut (
        .ddr_clk(clk), .ddr_rstn(rstn), .init_done(init_done),
        .ddr_rreq(rreq), .ddr_raddr(raddr), .ddr_rd_len(rd_len),
        .ddr_rrdy(rrdy), .ddr_rdone(rdone), .ddr_rdata(rdata),
        .ddr_rdata_en1(en1), .ddr_rdata_en2(en2), .rd_opera_en_2(part_sel),
        .axi_araddr(araddr), .axi_arlen(arlen), .axi_arvalid(arvalid),
        .axi_arready(arready), .axi_rdata(axi_rdata), .axi_rvalid(rvalid),
        .axi_rready(rready)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic part; logic [AW-1:0] addr; logic [7:0] len; } burst_t;
    typedef struct { logic part; logic [DW-1:0] data; } beat_t;

    burst_t burst_q[$];
    beat_t  beat_q[$];
    logic   done_q[$];

    int n_checks = 0, n_bad = 0;
    int n_rrdy = 0, n_done = 0, n_en = 0;
    int beats_left = 0, ar_wait = 0, ar_delay = 0;
    bit gap = 0, tog = 0, ar_pend = 0, cur_part = 0;
    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_len;

    task automatic expect_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push_part(input logic p, input logic [AW-1:0] a, input logic [LW-1:0] l);
        logic [AW-1:0] ad;
        int r, b;
        ad = a;
        r  = int'(l);
        while (r > 0) begin
            b = (r > MB) ? MB : r;
            burst_q.push_back('{part: p, addr: ad, len: 8'(b - 1)});
            ad = ad + AW'(b * STEP);
            r -= b;
        end
        done_q.push_back(p);
    endtask

    task automatic check_quiet(input string tag);
        expect_eq({tag, "_ctrl"}, {rrdy, rdone, en1, en2, part_sel, araddr, arlen, arvalid, rready}, '0);
        expect_eq({tag, "_data"}, rdata, '0);
    endtask

    task automatic run_line(input logic [AW-1:0] a0, input logic [LW-1:0] l0,
                            input logic [AW-1:0] a1, input logic [LW-1:0] l1);
        int e0, d0, r0, k;
        e0 = n_en; d0 = n_done; r0 = n_rrdy;
        line_addr0 = a0; line_len0 = l0; line_addr1 = a1; line_len1 = l1;
        push_part(1'b0, a0, l0);
        push_part(1'b1, a1, l1);
        rreq = 1'b1;
        k = 0;
        while (n_rrdy == r0 && k < 100) begin @(posedge clk); #1; k++; end
        if (k >= 100) expect_eq("rrdy_timeout", 1, 0);
        rreq = 1'b0;
        k = 0;
        while (n_done < d0 + 2 && k < 3000) begin @(posedge clk); #1; k++; end
        if (k >= 3000) expect_eq("rdone_timeout", 1, 0);
        repeat (4) @(posedge clk);
        #1;
        expect_eq("rrdy_once", n_rrdy - r0, 1);
        expect_eq("rdone_count", n_done - d0, 2);
        expect_eq("beat_count", n_en - e0, int'(l0) + int'(l1));
        expect_eq("bursts_left", burst_q.size(), 0);
        expect_eq("beats_pending", beat_q.size(), 0);
        expect_eq("part_back", part_sel, 0);
    endtask

    // Monitor plus AXI slave, evaluated at the falling edge. Inputs set here
    // are what the DUT samples at the next rising edge.
    initial begin
        beat_t  b;
        burst_t e;
        logic   p;
        arready = 1'b0; rvalid = 1'b0; axi_rdata = '0;
        forever begin
            @(negedge clk);
            if (en1 || en2) begin
                n_en++;
                expect_eq("en_exclusive", en1 & en2, 0);
                if (beat_q.size() == 0) expect_eq("beat_unexpected", 1, 0);
                else begin
                    b = beat_q.pop_front();
                    expect_eq("beat_part", en2, b.part);
                    expect_eq("beat_data", rdata, b.data);
                end
            end
            if (rdone) begin
                n_done++;
                if (done_q.size() == 0) expect_eq("rdone_unexpected", 1, 0);
                else begin
                    p = done_q.pop_front();
                    expect_eq("rdone_part", part_sel, p);
                    expect_eq("rdone_early", beat_q.size() + beats_left, 0);
                end
            end
            if (rrdy) n_rrdy++;

            if (!rstn) begin
                arready = 1'b0; rvalid = 1'b0;
                beats_left = 0; ar_wait = 0; ar_pend = 0;
            end else begin
                if (ar_pend) expect_eq("ar_hold", {arvalid, araddr, arlen}, {1'b1, pend_addr, pend_len});
                ar_pend = 0;
                if (arvalid) begin
                    arready = (ar_wait >= ar_delay);
                    ar_wait++;
                end else begin
                    arready = 1'b0;
                    ar_wait = 0;
                end
                if (arvalid && arready) begin
                    ar_wait = 0;
                    if (burst_q.size() == 0) expect_eq("ar_unexpected", 1, 0);
                    else begin
                        e = burst_q.pop_front();
                        expect_eq("ar_addr", araddr, e.addr);
                        expect_eq("ar_len", arlen, e.len);
                        beats_left += int'(arlen) + 1;
                        cur_part = e.part;
                    end
                end else if (arvalid) begin
                    ar_pend = 1; pend_addr = araddr; pend_len = arlen;
                end
                tog = ~tog;
                if (beats_left > 0 && (!gap || tog)) begin
                    rvalid = 1'b1;
                    for (int i = 0; i < 8; i++) axi_rdata[i*32 +: 32] = $urandom();
                end else begin
                    rvalid = 1'b0;
                end
                if (rvalid && rready) begin
                    beat_q.push_back('{part: cur_part, data: axi_rdata});
                    beats_left--;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, k;
        rstn = 1'b0; rreq = 1'b1; init_done = 1'b0;
        line_addr0 = '0; line_addr1 = '0; line_len0 = '0; line_len1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(posedge clk);
        #3 rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_eq("no_rrdy_wo_init", n_rrdy, 0);
        check_quiet("idle_wo_init");

        // Two 16-beat parts, one burst each; request has been held since reset.
        init_done = 1'b1;
        run_line(AW'('h100), LW'(16), AW'('h8100), LW'(16));
        expect_eq("rrdy_total", n_rrdy, 1);

        // 40 beats splits 16/16/8.
        run_line(AW'('h0), LW'(40), AW'('h1000), LW'(5));

        // Slow address accept and gapped data.
        ar_delay = 5; gap = 1;
        run_line(AW'('h2000), LW'(20), AW'('h3000), LW'(7));
        ar_delay = 0; gap = 0;

        // Empty part 1: no burst, no en2, still two rdone pulses.
        run_line(AW'('h400), LW'(16), AW'('h500), LW'(0));

        // Address wrap at the top of the DDR space.
        run_line(AW'('h7FF_FFF0), LW'(24), AW'('h40), LW'(3));

        // Reset in the middle of a burst.
        e0 = n_en;
        line_addr0 = AW'('h600); line_len0 = LW'(16);
        line_addr1 = AW'('h700); line_len1 = LW'(16);
        push_part(1'b0, line_addr0, line_len0);
        push_part(1'b1, line_addr1, line_len1);
        rreq = 1'b1;
        k = 0;
        while (n_en < e0 + 3 && k < 200) begin @(posedge clk); #1; k++; end
        if (k >= 200) expect_eq("midburst_timeout", 1, 0);
        rreq = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_quiet("midburst_reset");
        burst_q.delete(); beat_q.delete(); done_q.delete();
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        check_quiet("after_release");
        run_line(AW'('h900), LW'(18), AW'('hA00), LW'(16));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
